// File: rtl/decode.sv
// Instruction decode stage: register file with write-through bypass, control decode,
// branch/jump resolution with a one-slot squash, and the ID/EX pipeline register.
module decode (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] if_id_instruc,
   input  logic [31:0] if_id_nextpc,
   input  logic        ex_if_stall,
   input  logic        wb_id_regwrite,
   input  logic [4:0]  wb_id_writereg,
   input  logic [31:0] wb_id_writedata,
   output logic        id_if_selpcsource,
   output logic [1:0]  id_if_selpctype,
   output logic [31:0] id_if_rega,
   output logic [31:0] id_if_pcimd2ext,
   output logic [31:0] id_if_pcindex,
   output logic [31:0] id_ex_rega,
   output logic [31:0] id_ex_regb,
   output logic [31:0] id_ex_imedext,
   output logic [4:0]  id_ex_regdest,
   output logic [2:0]  id_ex_aluop,
   output logic        id_ex_alusrc,
   output logic        id_ex_regwrite,
   output logic        id_ex_memread,
   output logic        id_ex_memwrite
);

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b100
   } alu_op_e;

   logic [31:0] regs [32];
   logic        squash;

   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm;
   logic [31:0] rs_val, rt_val, imm_ext;
   logic        unused_shamt;

   assign opcode       = if_id_instruc[31:26];
   assign rs           = if_id_instruc[25:21];
   assign rt           = if_id_instruc[20:16];
   assign rd           = if_id_instruc[15:11];
   assign funct        = if_id_instruc[5:0];
   assign imm          = if_id_instruc[15:0];
   assign imm_ext      = {{16{imm[15]}}, imm};
   assign unused_shamt = ^if_id_instruc[10:6];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (wb_id_regwrite && wb_id_writereg != 5'd0) begin
         regs[wb_id_writereg] <= wb_id_writedata;
      end
   end

   // A writeback landing this cycle must be visible to the instruction being decoded now.
   always_comb begin
      rs_val = regs[rs];
      rt_val = regs[rt];
      if (rs == 5'd0) rs_val = '0;
      else if (wb_id_regwrite && wb_id_writereg == rs) rs_val = wb_id_writedata;
      if (rt == 5'd0) rt_val = '0;
      else if (wb_id_regwrite && wb_id_writereg == rt) rt_val = wb_id_writedata;
   end

   logic       keep, redirect_raw, redirect_req, r_arith;
   logic [1:0] pc_type;
   alu_op_e    dec_aluop;
   logic [4:0] dec_regdest;
   logic       dec_alusrc, dec_regwrite, dec_memread, dec_memwrite;

   always_comb begin
      keep         = 1'b0;
      redirect_raw = 1'b0;
      pc_type      = 2'b00;
      r_arith      = 1'b0;
      dec_aluop    = ALU_ADD;
      dec_regdest  = 5'd0;
      dec_alusrc   = 1'b0;
      dec_regwrite = 1'b0;
      dec_memread  = 1'b0;
      dec_memwrite = 1'b0;
      case (opcode)
         6'h00: begin
            case (funct)
               6'h20: begin r_arith = 1'b1; dec_aluop = ALU_ADD; end
               6'h22: begin r_arith = 1'b1; dec_aluop = ALU_SUB; end
               6'h24: begin r_arith = 1'b1; dec_aluop = ALU_AND; end
               6'h25: begin r_arith = 1'b1; dec_aluop = ALU_OR;  end
               6'h2A: begin r_arith = 1'b1; dec_aluop = ALU_SLT; end
               6'h08: begin redirect_raw = 1'b1; pc_type = 2'b01; end
               default: begin redirect_raw = 1'b1; pc_type = 2'b11; end
            endcase
            if (r_arith) begin
               keep         = 1'b1;
               dec_regdest  = rd;
               dec_regwrite = 1'b1;
            end
         end
         6'h23: begin
            keep = 1'b1; dec_alusrc = 1'b1; dec_memread = 1'b1;
            dec_regwrite = 1'b1; dec_regdest = rt;
         end
         6'h2B: begin
            keep = 1'b1; dec_alusrc = 1'b1; dec_memwrite = 1'b1; dec_regdest = rt;
         end
         6'h08: begin
            keep = 1'b1; dec_alusrc = 1'b1; dec_regwrite = 1'b1; dec_regdest = rt;
         end
         6'h04: redirect_raw = (rs_val == rt_val);
         6'h05: redirect_raw = (rs_val != rt_val);
         6'h02: begin redirect_raw = 1'b1; pc_type = 2'b10; end
         default: begin redirect_raw = 1'b1; pc_type = 2'b11; end
      endcase
   end

   // The slot behind a taken redirect is wrong-path: it neither redirects nor issues.
   assign redirect_req      = redirect_raw & ~squash;
   assign id_if_selpcsource = redirect_req & ~ex_if_stall;
   assign id_if_selpctype   = redirect_req ? pc_type : 2'b00;
   assign id_if_rega        = rs_val;
   assign id_if_pcimd2ext   = if_id_nextpc + {imm_ext[29:0], 2'b00};
   assign id_if_pcindex     = {if_id_nextpc[31:28], if_id_instruc[25:0], 2'b00};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         squash         <= 1'b0;
         id_ex_rega     <= '0;
         id_ex_regb     <= '0;
         id_ex_imedext  <= '0;
         id_ex_regdest  <= '0;
         id_ex_aluop    <= '0;
         id_ex_alusrc   <= 1'b0;
         id_ex_regwrite <= 1'b0;
         id_ex_memread  <= 1'b0;
         id_ex_memwrite <= 1'b0;
      end else if (!ex_if_stall) begin
         squash <= id_if_selpcsource;
         if (keep && !squash) begin
            id_ex_rega     <= rs_val;
            id_ex_regb     <= rt_val;
            id_ex_imedext  <= imm_ext;
            id_ex_regdest  <= dec_regdest;
            id_ex_aluop    <= dec_aluop;
            id_ex_alusrc   <= dec_alusrc;
            id_ex_regwrite <= dec_regwrite;
            id_ex_memread  <= dec_memread;
            id_ex_memwrite <= dec_memwrite;
         end else begin
            id_ex_rega     <= '0;
            id_ex_regb     <= '0;
            id_ex_imedext  <= '0;
            id_ex_regdest  <= '0;
            id_ex_aluop    <= '0;
            id_ex_alusrc   <= 1'b0;
            id_ex_regwrite <= 1'b0;
            id_ex_memread  <= 1'b0;
            id_ex_memwrite <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: ID/EX expectations are queued when an instruction is
// driven and compared after the clock edge that loads them.
module tb_decode;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] instruc = 32'h2000_0000;
   logic [31:0] nextpc = '0;
   logic        stall = 1'b0;
   logic        wb_regwrite = 1'b0;
   logic [4:0]  wb_writereg = '0;
   logic [31:0] wb_writedata = '0;
   logic        selpcsource;
   logic [1:0]  selpctype;
   logic [31:0] if_rega, pcimd2ext, pcindex;
   logic [31:0] ex_rega, ex_regb, ex_imedext;
   logic [4:0]  ex_regdest;
   logic [2:0]  ex_aluop;
   logic        ex_alusrc, ex_regwrite, ex_memread, ex_memwrite;

   decode dut (
      .clock(clock), .reset(reset),
      .if_id_instruc(instruc), .if_id_nextpc(nextpc), .ex_if_stall(stall),
      .wb_id_regwrite(wb_regwrite), .wb_id_writereg(wb_writereg), .wb_id_writedata(wb_writedata),
      .id_if_selpcsource(selpcsource), .id_if_selpctype(selpctype), .id_if_rega(if_rega),
      .id_if_pcimd2ext(pcimd2ext), .id_if_pcindex(pcindex),
      .id_ex_rega(ex_rega), .id_ex_regb(ex_regb), .id_ex_imedext(ex_imedext),
      .id_ex_regdest(ex_regdest), .id_ex_aluop(ex_aluop), .id_ex_alusrc(ex_alusrc),
      .id_ex_regwrite(ex_regwrite), .id_ex_memread(ex_memread), .id_ex_memwrite(ex_memwrite)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [31:0] rega;
      logic [31:0] regb;
      logic [31:0] imedext;
      logic [4:0]  regdest;
      logic [2:0]  aluop;
      logic        alusrc;
      logic        regwrite;
      logic        memread;
      logic        memwrite;
   } idex_t;

   localparam logic [31:0] NOP = 32'h2000_0000;
   localparam idex_t BUBBLE = '0;

   idex_t sb[$];
   idex_t got, want;
   int    assert_count = 0;
   int    fail_count = 0;

   function automatic idex_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] i,
                                input logic [4:0] rd, input logic [2:0] op, input logic src,
                                input logic rw, input logic mr, input logic mw);
      return {a, b, i, rd, op, src, rw, mr, mw};
   endfunction

   function idex_t observed();
      return {ex_rega, ex_regb, ex_imedext, ex_regdest, ex_aluop,
              ex_alusrc, ex_regwrite, ex_memread, ex_memwrite};
   endfunction

   task automatic drive(input logic [31:0] ins, input logic [31:0] npc, input logic stl,
                        input logic wr, input logic [4:0] wreg, input logic [31:0] wdata);
      @(negedge clock);
      instruc = ins; nextpc = npc; stall = stl;
      wb_regwrite = wr; wb_writereg = wreg; wb_writedata = wdata;
      #1;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      drive(32'h00A5_1820, 32'h4, 1'b0, 1'b0, 5'd0, '0);
      tick();
      assert_count++;
      if (observed() !== BUBBLE) begin
         fail_count++; $display("[TB] FAIL reset_idex got %h want %h", observed(), BUBBLE);
      end
      assert_count++;
      if (if_rega !== 32'h0) begin
         fail_count++; $display("[TB] FAIL reset_regfile got %h want 0", if_rega);
      end
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_rtype_bypass();
      drive(NOP, 32'h0, 1'b0, 1'b1, 5'd5, 32'h0000_1234);
      tick();
      drive(32'h00A5_1820, 32'h4, 1'b0, 1'b0, 5'd0, '0);
      sb.push_back(mk(32'h1234, 32'h1234, 32'h1820, 5'd3, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0));
      assert_count++;
      if (if_rega !== 32'h1234) begin
         fail_count++; $display("[TB] FAIL add_if_rega got %h want %h", if_rega, 32'h1234);
      end
      tick();
      got = observed(); want = sb.pop_front(); assert_count++;
      if (got !== want) begin
         fail_count++; $display("[TB] FAIL add_idex got %h want %h", got, want);
      end
      drive(32'h00A5_1822, 32'h8, 1'b0, 1'b1, 5'd5, 32'hBEEF_0001);
      sb.push_back(mk(32'hBEEF_0001, 32'hBEEF_0001, 32'h1822, 5'd3, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0));
      assert_count++;
      if (if_rega !== 32'hBEEF_0001) begin
         fail_count++; $display("[TB] FAIL bypass_if_rega got %h want %h", if_rega, 32'hBEEF_0001);
      end
      tick();
      got = observed(); want = sb.pop_front(); assert_count++;
      if (got !== want) begin
         fail_count++; $display("[TB] FAIL bypass_idex got %h want %h", got, want);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ins [6];
      logic        wr [6];
      logic [31:0] wd [6];
      idex_t       ex [6];
      ins[0] = 32'h00A0_182A; wr[0] = 0; wd[0] = '0;
      ex[0] = mk(32'hBEEF_0001, 0, 32'h182A, 5'd3, 3'b100, 0, 1, 0, 0);
      ins[1] = 32'h00A0_1824; wr[1] = 0; wd[1] = '0;
      ex[1] = mk(32'hBEEF_0001, 0, 32'h1824, 5'd3, 3'b010, 0, 1, 0, 0);
      ins[2] = 32'h00A0_1825; wr[2] = 0; wd[2] = '0;
      ex[2] = mk(32'hBEEF_0001, 0, 32'h1825, 5'd3, 3'b011, 0, 1, 0, 0);
      ins[3] = 32'h20A9_FFFF; wr[3] = 0; wd[3] = '0;
      ex[3] = mk(32'hBEEF_0001, 0, 32'hFFFF_FFFF, 5'd9, 3'b000, 1, 1, 0, 0);
      ins[4] = 32'hAC05_0008; wr[4] = 0; wd[4] = '0;
      ex[4] = mk(0, 32'hBEEF_0001, 32'h8, 5'd5, 3'b000, 1, 0, 0, 1);
      ins[5] = 32'h0000_1820; wr[5] = 1; wd[5] = 32'hFFFF;
      ex[5] = mk(0, 0, 32'h1820, 5'd3, 3'b000, 0, 1, 0, 0);
      for (int k = 0; k < 6; k++) begin
         drive(ins[k], 32'h20, 1'b0, wr[k], 5'd0, wd[k]);
         sb.push_back(ex[k]);
         tick();
         got = observed(); want = sb.pop_front(); assert_count++;
         if (got !== want) begin
            fail_count++; $display("[TB] FAIL op%0d_idex got %h want %h", k, got, want);
         end
      end
   endtask

   // Each row: instruction, nextpc, expected selpcsource/selpctype, expected ID/EX contents.
   task automatic test_redirects();
      logic [31:0] ins [14];
      logic [31:0] npc [14];
      logic        src [14];
      logic [1:0]  typ [14];
      idex_t       ex [14];
      for (int k = 0; k < 14; k++) begin npc[k] = 32'h100; ex[k] = BUBBLE; end
      ins[0]  = 32'h1000_0004; src[0]  = 1; typ[0]  = 2'b00;
      ins[1]  = 32'h0800_0010; src[1]  = 0; typ[1]  = 2'b00;
      ins[2]  = 32'h00A5_1820; src[2]  = 0; typ[2]  = 2'b00;
      ex[2] = mk(32'hBEEF_0001, 32'hBEEF_0001, 32'h1820, 5'd3, 3'b000, 0, 1, 0, 0);
      ins[3]  = 32'h0800_0010; src[3]  = 1; typ[3]  = 2'b10; npc[3] = 32'h1000_0004;
      ins[4]  = NOP;           src[4]  = 0; typ[4]  = 2'b00;
      ins[5]  = 32'h03E0_0008; src[5]  = 1; typ[5]  = 2'b01;
      ins[6]  = NOP;           src[6]  = 0; typ[6]  = 2'b00;
      ins[7]  = 32'hFC00_0000; src[7]  = 1; typ[7]  = 2'b11;
      ins[8]  = NOP;           src[8]  = 0; typ[8]  = 2'b00;
      ins[9]  = 32'h1400_0004; src[9]  = 0; typ[9]  = 2'b00;
      ins[10] = 32'h10A0_0004; src[10] = 0; typ[10] = 2'b00;
      ins[11] = 32'h0000_0000; src[11] = 1; typ[11] = 2'b11;
      ins[12] = NOP;           src[12] = 0; typ[12] = 2'b00;
      ins[13] = 32'h1500_FFFF; src[13] = 0; typ[13] = 2'b00;
      drive(NOP, 32'h0, 1'b0, 1'b1, 5'd31, 32'h200);
      tick();
      for (int k = 0; k < 14; k++) begin
         drive(ins[k], npc[k], 1'b0, 1'b0, 5'd0, '0);
         sb.push_back(ex[k]);
         assert_count++;
         if (selpcsource !== src[k] || selpctype !== typ[k]) begin
            fail_count++;
            $display("[TB] FAIL redir%0d_sel got %b/%b want %b/%b", k, selpcsource, selpctype, src[k], typ[k]);
         end
         if (k == 0) begin
            assert_count++;
            if (pcimd2ext !== 32'h110) begin
               fail_count++; $display("[TB] FAIL beq_target got %h want %h", pcimd2ext, 32'h110);
            end
         end
         if (k == 3) begin
            assert_count++;
            if (pcindex !== 32'h1000_0040) begin
               fail_count++; $display("[TB] FAIL j_target got %h want %h", pcindex, 32'h1000_0040);
            end
         end
         if (k == 5) begin
            assert_count++;
            if (if_rega !== 32'h200) begin
               fail_count++; $display("[TB] FAIL jr_target got %h want %h", if_rega, 32'h200);
            end
         end
         if (k == 13) begin
            assert_count++;
            if (pcimd2ext !== 32'hFC) begin
               fail_count++; $display("[TB] FAIL neg_target got %h want %h", pcimd2ext, 32'hFC);
            end
         end
         tick();
         got = observed(); want = sb.pop_front(); assert_count++;
         if (got !== want) begin
            fail_count++; $display("[TB] FAIL redir%0d_idex got %h want %h", k, got, want);
         end
      end
   endtask

   task automatic test_stall_reset();
      idex_t lw_exp;
      lw_exp = mk(32'hBEEF_0001, 0, 32'hFFFF_FFFC, 5'd7, 3'b000, 1, 1, 1, 0);
      drive(32'h8CA7_FFFC, 32'h40, 1'b0, 1'b0, 5'd0, '0);
      sb.push_back(lw_exp);
      tick();
      got = observed(); want = sb.pop_front(); assert_count++;
      if (got !== want) begin
         fail_count++; $display("[TB] FAIL lw_idex got %h want %h", got, want);
      end
      for (int k = 0; k < 3; k++) begin
         drive(32'hFC00_0000, 32'h44, 1'b1, 1'b0, 5'd0, '0);
         sb.push_back(lw_exp);
         assert_count++;
         if (selpcsource !== 1'b0) begin
            fail_count++; $display("[TB] FAIL stall%0d_selpc got %b want 0", k, selpcsource);
         end
         tick();
         got = observed(); want = sb.pop_front(); assert_count++;
         if (got !== want) begin
            fail_count++; $display("[TB] FAIL stall%0d_hold got %h want %h", k, got, want);
         end
      end
      drive(32'h00A5_1820, 32'h44, 1'b1, 1'b0, 5'd0, '0);
      #1 reset = 1'b0;
      #1;
      assert_count++;
      if (observed() !== BUBBLE || if_rega !== 32'h0) begin
         fail_count++; $display("[TB] FAIL async_reset got %h/%h want %h/0", observed(), if_rega, BUBBLE);
      end
      @(negedge clock);
      reset = 1'b1;
      drive(32'h00A5_1820, 32'h48, 1'b0, 1'b0, 5'd0, '0);
      sb.push_back(mk(0, 0, 32'h1820, 5'd3, 3'b000, 0, 1, 0, 0));
      tick();
      got = observed(); want = sb.pop_front(); assert_count++;
      if (got !== want) begin
         fail_count++; $display("[TB] FAIL post_reset_idex got %h want %h", got, want);
      end
      drive(32'h1000_0004, 32'h100, 1'b0, 1'b0, 5'd0, '0);
      tick();
      @(negedge clock);
      reset = 1'b0;
      #2 reset = 1'b1;
      #1;
      instruc = 32'h0800_0010; nextpc = 32'h1000_0004;
      #1;
      sb.push_back(BUBBLE);
      assert_count++;
      if (selpcsource !== 1'b1 || selpctype !== 2'b10) begin
         fail_count++; $display("[TB] FAIL squash_reset_sel got %b/%b want 1/10", selpcsource, selpctype);
      end
      tick();
      got = observed(); want = sb.pop_front(); assert_count++;
      if (got !== want) begin
         fail_count++; $display("[TB] FAIL squash_reset_idex got %h want %h", got, want);
      end
   endtask

   initial begin
      test_reset();
      test_rtype_bypass();
      test_back_to_back();
      test_redirects();
      test_stall_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports SHALL be named clock and reset.
REQ-002 clock  in  1  rising-edge clock.
REQ-003 reset  in  1  async active-low reset.
REQ-004 if_id_instruc  in  32  instruction from Fetch.
REQ-005 if_id_nextpc  in  32  PC+4 of that instruction.
REQ-006 ex_if_stall  in  1  pipeline stall from Execute.
REQ-007 wb_id_regwrite / wb_id_writereg / wb_id_writedata  in  1/5/32  writeback port.
REQ-008 id_if_selpcsource  out  1  redirect Fetch.
REQ-009 id_if_selpctype  out  2  00 pcimd2ext, 01 rega, 10 pcindex, 11 vector 32'd64.
REQ-010 id_if_rega / id_if_pcimd2ext / id_if_pcindex  out  32 each  redirect targets.
REQ-011 id_ex_rega / id_ex_regb / id_ex_imedext  out  32 each  operands, sign-extended immediate.
REQ-012 id_ex_regdest  out  5  destination register.
REQ-013 id_ex_aluop  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt.
REQ-014 id_ex_alusrc / id_ex_regwrite / id_ex_memread / id_ex_memwrite  out  1 each  controls.

Function
REQ-015 Register file SHALL be 32x32; r0 reads 0; write on rising edge when wb_id_regwrite=1 and writereg!=0, regardless of stall.
REQ-016 Reads SHALL bypass: same-cycle write to the read register returns wb_id_writedata.
REQ-017 Decoding: R-type (op 0) funct 20/22/24/25/2A -> add/sub/and/or/slt, regdest=rd, alusrc 0, regwrite 1.
REQ-018 lw (23h): add, alusrc 1, memread 1, regwrite 1, regdest=rt; sw (2Bh): add, alusrc 1, memwrite 1; addi (08h): add, alusrc 1, regwrite 1, regdest=rt.
REQ-019 beq (04h)/bne (05h) SHALL compare bypassed rs/rt in this stage; taken -> selpcsource 1, selpctype 00.
REQ-020 j (02h) -> selpctype 10; jr (op 0, funct 08h) -> selpctype 01; both always taken.
REQ-021 Any other opcode/funct SHALL redirect with selpctype 11 and be bubbled.
REQ-022 id_if_pcimd2ext = nextpc + (signext(imm16)<<2); id_if_pcindex = {nextpc[31:28], instr[25:0], 2'b00}; id_if_rega = bypassed rs; all mod 2^32, combinational.
REQ-023 id_if_selpcsource SHALL be combinational and forced 0 while ex_if_stall=1 or squash=1.
REQ-024 ID/EX register SHALL load on rising edge only when ex_if_stall=0; it SHALL hold all values while stalled.
REQ-025 Branches, jumps, illegal ops and squashed instructions SHALL load a bubble: all controls 0, aluop 000, operands 0.
REQ-026 squash flag SHALL set on a non-stalled edge where selpcsource=1 and clear on the next non-stalled edge; the instruction seen while squash=1 is bubbled, never redirects.
REQ-027 id_if_selpctype SHALL be 00 when no redirect is requested.

Reset
REQ-028 reset=0 SHALL immediately clear all id_ex_* outputs, squash flag and all 32 registers to 0.
REQ-029 Reset asserted mid-stall or mid-squash SHALL discard that state; first post-reset instruction decodes normally.

Verification
REQ-030 WB r5=0x1234, then 0x00A51820 (add r3,r5,r5) -> id_ex_rega=regb=0x1234, regdest=3, aluop 000, regwrite 1; also same-cycle WB r5 bypass.
REQ-031 nextpc=0x100, 0x10000004 (beq r0,r0,4) -> selpcsource 1, selpctype 00, pcimd2ext=0x110; next instruction bubbled, selpcsource 0.
REQ-032 nextpc=0x10000004, 0x08000010 (j) -> selpctype 10, pcindex=0x10000040; 0x03E00008 with r31=0x200 -> selpctype 01, rega=0x200.
REQ-033 0xFC000000 -> selpcsource 1, selpctype 11, ID/EX bubble; bne r0,r0 -> no redirect.
REQ-034 lw then ex_if_stall=1 for 3 cycles -> ID/EX holds memread 1, selpcsource 0; reset=0 during stall -> all outputs 0 asynchronously.
